// File: rtl/irq_arb_pkg.sv
// rtl/irq_arb_pkg.sv - shared types and constants for the interrupt arbiter
package irq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } arb_state_t;

  localparam logic [31:0] CAUSE_BASE_DEF = 32'h1000_0010;

  function automatic int irq_idx_w(input int n_irq);
    return $clog2(n_irq);
  endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// rtl/irq_prio_sel.sv - combinational selector: first set bit at or after start, wrapping
module irq_prio_sel
  import irq_arb_pkg::*;
#(
  parameter int N_IRQ = 16,
  parameter int IDX_W = irq_idx_w(N_IRQ)
) (
  input  logic [N_IRQ-1:0] elig_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the farthest offset down so the nearest eligible line is assigned last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      int j;
      j = int'(start_i) + i;
      if (j >= N_IRQ) j = j - N_IRQ;
      if (elig_i[j]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - edge-latching interrupt arbiter with request/serve handshake
// Optional round-robin selection: IRQ_ARB_ROUND_ROBIN_EN
module irq_arbiter
  import irq_arb_pkg::*;
#(
  parameter int          N_IRQ      = 16,
  parameter logic [31:0] CAUSE_BASE = CAUSE_BASE_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_lines_i,
  input  logic [N_IRQ-1:0] irq_mask_i,
  input  logic             irq_ack_i,
  input  logic             irq_ret_i,
  output logic             irq_req_o,
  output logic [31:0]      irq_cause_o,
  output logic [N_IRQ-1:0] irq_served_o,
  output logic             irq_busy_o
);

  localparam int W = irq_idx_w(N_IRQ);

  arb_state_t       state_q;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [W-1:0]     win_q;
  logic             req_q;
  logic [31:0]      cause_q;
  logic [N_IRQ-1:0] served_q;

  logic [N_IRQ-1:0] rise, elig, win_oh, clr;
  logic [W-1:0]     start;
  logic             sel_valid;
  logic [W-1:0]     sel_idx;
  logic             ack_hit;

  assign rise    = irq_lines_i & ~prev_q;
  assign elig    = pending_q & irq_mask_i;
  assign win_oh  = {{(N_IRQ-1){1'b0}}, 1'b1} << win_q;
  assign ack_hit = (state_q == REQ) && irq_ack_i;
  assign clr     = ack_hit ? win_oh : '0;
  // A fresh edge in the ack cycle must survive the clear.
  assign pending_d = (pending_q & ~clr) | rise;

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [W-1:0] rr_ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (ack_hit) begin
      rr_ptr_q <= (win_q == W'(N_IRQ - 1)) ? '0 : win_q + 1'b1;
    end
  end

  assign start = rr_ptr_q;
`else
  assign start = '0;
`endif

  irq_prio_sel #(
    .N_IRQ (N_IRQ),
    .IDX_W (W)
  ) u_sel (
    .elig_i  (elig),
    .start_i (start),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      win_q     <= '0;
      req_q     <= 1'b0;
      cause_q   <= CAUSE_BASE;
      served_q  <= '0;
    end else begin
      prev_q    <= irq_lines_i;
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            win_q   <= sel_idx;
            cause_q <= CAUSE_BASE + 32'(sel_idx);
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            req_q    <= 1'b0;
            served_q <= win_oh;
            state_q  <= SERVE;
          end else if (!irq_mask_i[win_q]) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        SERVE: begin
          if (irq_ret_i) begin
            served_q <= '0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq_req_o    = req_q;
  assign irq_cause_o  = cause_q;
  assign irq_served_o = served_q;
  assign irq_busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - directed self-checking bench for irq_arbiter (round-robin test under IRQ_ARB_ROUND_ROBIN_EN)
module tb_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lines, mask;
  logic        ack, ret;
  logic        req, busy;
  logic [31:0] cause;
  logic [15:0] served;

  int checks = 0;
  int failures = 0;

  irq_arbiter #(.N_IRQ(16), .CAUSE_BASE(32'h1000_0010)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .irq_lines_i  (lines),
    .irq_mask_i   (mask),
    .irq_ack_i    (ack),
    .irq_ret_i    (ret),
    .irq_req_o    (req),
    .irq_cause_o  (cause),
    .irq_served_o (served),
    .irq_busy_o   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] v);
    lines = v;
    tick();
    lines = '0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_ret();
    ret = 1'b1;
    tick();
    ret = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; lines = '0; mask = 16'hFFFF; ack = 1'b0; ret = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req !== 1'b0 || busy !== 1'b0 || served !== 16'h0 || cause !== 32'h1000_0010) begin
      failures++;
      $display("FAIL reset: req=%b busy=%b served=%h cause=%h, want 0 0 0000 10000010", req, busy, served, cause);
    end
  endtask

  task automatic test_single();
    pulse(16'h0008);
    checks++;
    if (req !== 1'b0) begin failures++; $display("FAIL single_t1: req=%b want 0", req); end
    tick();
    checks++;
    if (req !== 1'b1 || cause !== 32'h1000_0013) begin
      failures++; $display("FAIL single_req: req=%b cause=%h want 1 10000013", req, cause);
    end
    do_ack();
    checks++;
    if (served !== 16'h0008 || busy !== 1'b1 || req !== 1'b0) begin
      failures++; $display("FAIL single_serve: served=%h busy=%b req=%b want 0008 1 0", served, busy, req);
    end
    do_ret();
    checks++;
    if (busy !== 1'b0 || served !== 16'h0) begin
      failures++; $display("FAIL single_ret: busy=%b served=%h want 0 0000", busy, served);
    end
  endtask

  task automatic test_priority();
    pulse(16'h0024);
    tick();
    checks++;
    if (req !== 1'b1 || cause !== 32'h1000_0012) begin
      failures++; $display("FAIL prio_first: req=%b cause=%h want 1 10000012", req, cause);
    end
    do_ack();
    do_ret();
    checks++;
    if (req !== 1'b0) begin failures++; $display("FAIL prio_gap: req=%b want 0", req); end
    tick();
    checks++;
    if (req !== 1'b1 || cause !== 32'h1000_0015) begin
      failures++; $display("FAIL prio_second: req=%b cause=%h want 1 10000015", req, cause);
    end
    do_ack();
    do_ret();
  endtask

  task automatic test_no_preempt();
    pulse(16'h0080);
    tick();
    pulse(16'h0002);
    tick();
    checks++;
    if (req !== 1'b1 || cause !== 32'h1000_0017) begin
      failures++; $display("FAIL nopre_req: req=%b cause=%h want 1 10000017", req, cause);
    end
    do_ack();
    checks++;
    if (served !== 16'h0080 || cause !== 32'h1000_0017) begin
      failures++; $display("FAIL nopre_serve: served=%h cause=%h want 0080 10000017", served, cause);
    end
    do_ret();
    tick();
    checks++;
    if (req !== 1'b1 || cause !== 32'h1000_0011) begin
      failures++; $display("FAIL nopre_next: req=%b cause=%h want 1 10000011", req, cause);
    end
    do_ack();
    do_ret();
  endtask

  task automatic test_mask();
    mask = 16'hFFEF;
    pulse(16'h0010);
    tick();
    tick();
    checks++;
    if (req !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL mask_off: req=%b busy=%b want 0 0", req, busy);
    end
    mask = 16'hFFFF;
    tick();
    checks++;
    if (req !== 1'b1 || cause !== 32'h1000_0014) begin
      failures++; $display("FAIL mask_on: req=%b cause=%h want 1 10000014", req, cause);
    end
    mask = 16'hFFEF;
    tick();
    checks++;
    if (req !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL mask_withdraw: req=%b busy=%b want 0 0", req, busy);
    end
    mask = 16'hFFFF;
    tick();
    checks++;
    if (req !== 1'b1 || cause !== 32'h1000_0014) begin
      failures++; $display("FAIL mask_again: req=%b cause=%h want 1 10000014", req, cause);
    end
    do_ack();
    do_ret();
  endtask

  task automatic test_edge_in_ack();
    pulse(16'h0040);
    tick();
    lines = 16'h0040;
    do_ack();
    lines = '0;
    checks++;
    if (served !== 16'h0040) begin failures++; $display("FAIL eack_serve: served=%h want 0040", served); end
    do_ack();
    checks++;
    if (served !== 16'h0040 || busy !== 1'b1) begin
      failures++; $display("FAIL eack_ignore_ack: served=%h busy=%b want 0040 1", served, busy);
    end
    do_ret();
    tick();
    checks++;
    if (req !== 1'b1 || cause !== 32'h1000_0016) begin
      failures++; $display("FAIL eack_repend: req=%b cause=%h want 1 10000016", req, cause);
    end
    do_ack();
    do_ret();
  endtask

  task automatic test_held_line();
    lines = 16'h0200;
    tick();
    tick();
    do_ack();
    do_ret();
    tick();
    tick();
    checks++;
    if (req !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL held_no_repend: req=%b busy=%b want 0 0", req, busy);
    end
    lines = '0;
    tick();
  endtask

  task automatic test_mid_reset();
    pulse(16'h0008);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (req !== 1'b0 || busy !== 1'b0 || cause !== 32'h1000_0010) begin
      failures++; $display("FAIL mid_reset: req=%b busy=%b cause=%h want 0 0 10000010", req, busy, cause);
    end
  endtask

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    logic [31:0] exp_rr [4];
    exp_rr[0] = 32'h1000_0010; exp_rr[1] = 32'h1000_0011;
    exp_rr[2] = 32'h1000_0010; exp_rr[3] = 32'h1000_0011;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      if (r % 2 == 0) pulse(16'h0003);
      else tick();
      tick();
      checks++;
      if (req !== 1'b1 || cause !== exp_rr[r]) begin
        failures++; $display("FAIL rr_alt%0d: req=%b cause=%h want 1 %h", r, req, cause, exp_rr[r]);
      end
      do_ack();
      do_ret();
    end
    pulse(16'h4000);
    tick();
    do_ack();
    do_ret();
    pulse(16'h8001);
    tick();
    checks++;
    if (cause !== 32'h1000_001F) begin
      failures++; $display("FAIL rr_last: cause=%h want 1000001f", cause);
    end
    do_ack();
    do_ret();
    tick();
    checks++;
    if (req !== 1'b1 || cause !== 32'h1000_0010) begin
      failures++; $display("FAIL rr_wrap: req=%b cause=%h want 1 10000010", req, cause);
    end
    do_ack();
    do_ret();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_no_preempt();
    test_mask();
    test_edge_in_ack();
    test_held_line();
    test_mid_reset();
`ifdef IRQ_ARB_ROUND_ROBIN_EN
    test_round_robin();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
